// File: rtl/dispatch_fifo_if.sv
// Handshake bundle for dispatch_fifo: producer push side, consumer pop side, flush and occupancy.
// master = the environment driving micro-ops in and draining them; slave = the FIFO itself.
interface dispatch_fifo_if #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 4
);
    logic                         flush;
    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/dispatch_fifo.sv
// Micro-op dispatch FIFO: DEPTH-entry circular buffer with synchronous flush.
// Optional empty-FIFO pass-through when DISPATCH_FIFO_BYPASS_EN is defined.
module dispatch_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    dispatch_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic in_ready_w;
    logic empty_w;
    logic byp_active;
    logic push_wr;
    logic pop_rd;

    assign in_ready_w = (count_q < FULL_CNT);
    assign empty_w    = (count_q == '0);

`ifdef DISPATCH_FIFO_BYPASS_EN
    // Gated by reset so out_valid stays low while the FIFO is held in reset.
    assign byp_active    = reset && !bus.flush && bus.in_valid && empty_w;
    assign bus.out_valid = !empty_w || byp_active;
    assign bus.out_data  = byp_active ? bus.in_data : mem_q[head_q];
`else
    assign byp_active    = 1'b0;
    assign bus.out_valid = !empty_w;
    assign bus.out_data  = mem_q[head_q];
`endif

    assign bus.in_ready = in_ready_w;
    assign bus.count    = count_q;

    // A bypassed micro-op is consumed directly and never written to storage.
    assign pop_rd  = !empty_w && bus.out_ready && !bus.flush;
    assign push_wr = bus.in_valid && in_ready_w && !bus.flush && !(byp_active && bus.out_ready);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_rd)  head_d = head_q + 1'b1;
            if (push_wr) tail_d = tail_q + 1'b1;
            if (push_wr && !pop_rd)      count_d = count_q + 1'b1;
            else if (pop_rd && !push_wr) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_wr) mem_q[tail_q] <= bus.in_data;
        end
    end
endmodule
